// File: rtl/tmds_link_sequencer_if.sv
// Pixel-side bundle between the TMDS encoders, the link sequencer and the serializer top.
// The master modport drives the sequencer's inputs; the slave modport is the sequencer's view.
interface tmds_link_sequencer_if;
   logic       mmcm_locked;
   logic       vde;
   logic       hsync;
   logic       vsync;
   logic [9:0] enc_r;
   logic [9:0] enc_g;
   logic [9:0] enc_b;
   logic       serdes_rst;
   logic [9:0] tmds_r;
   logic [9:0] tmds_g;
   logic [9:0] tmds_b;
   logic       link_up;
   logic [2:0] state;

   modport master (
      output mmcm_locked, vde, hsync, vsync, enc_r, enc_g, enc_b,
      input  serdes_rst, tmds_r, tmds_g, tmds_b, link_up, state
   );

   modport slave (
      input  mmcm_locked, vde, hsync, vsync, enc_r, enc_g, enc_b,
      output serdes_rst, tmds_r, tmds_g, tmds_b, link_up, state
   );
endinterface

// File: rtl/tmds_link_sequencer.sv
// Brings a TMDS link up after MMCM lock: qualify lock, pulse serializer reset, send
// control-only training frames, then pass encoded video. Any loss of lock drops back to IDLE.
module tmds_link_sequencer #(
   parameter int unsigned LOCK_STABLE  = 16,
   parameter int unsigned RST_CYCLES   = 8,
   parameter int unsigned TRAIN_FRAMES = 2
) (
   input  logic                  PixelClk,
   input  logic                  pRst,
   tmds_link_sequencer_if.slave  link
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SRST   = 3'd1;
   localparam logic [2:0] ST_TRAIN  = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;

   localparam logic [9:0] TOK_IDLE = 10'h354;

   localparam logic [7:0] LOCK_TGT  = 8'(LOCK_STABLE);
   localparam logic [7:0] RST_TGT   = 8'(RST_CYCLES);
   localparam logic [3:0] FRAME_TGT = 4'(TRAIN_FRAMES);

   logic       lock_meta_q, lock_sync_q;
   logic       vs_prev_q;
   logic [2:0] state_q, state_d;
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic [7:0] rst_cnt_q, rst_cnt_d;
   logic [3:0] frame_cnt_q, frame_cnt_d;
   logic       serdes_rst_q, serdes_rst_d;
   logic       link_up_q, link_up_d;
   logic [9:0] tmds_r_q, tmds_r_d;
   logic [9:0] tmds_g_q, tmds_g_d;
   logic [9:0] tmds_b_q, tmds_b_d;
   logic [9:0] ctrl_tok;
   logic       vs_rise;

   always_comb begin
      unique case ({link.vsync, link.hsync})
         2'b00:   ctrl_tok = 10'h354;
         2'b01:   ctrl_tok = 10'h0AB;
         2'b10:   ctrl_tok = 10'h154;
         default: ctrl_tok = 10'h2AB;
      endcase
   end

   assign vs_rise = link.vsync & ~vs_prev_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      lock_cnt_d  = '0;
      rst_cnt_d   = '0;
      frame_cnt_d = '0;

      if (!lock_sync_q) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               lock_cnt_d = (lock_cnt_q == LOCK_TGT) ? lock_cnt_q : lock_cnt_q + 8'd1;
               if (lock_cnt_d == LOCK_TGT) state_d = ST_SRST;
            end
            ST_SRST: begin
               rst_cnt_d = rst_cnt_q + 8'd1;
               if (rst_cnt_d == RST_TGT) state_d = ST_TRAIN;
            end
            ST_TRAIN: begin
               frame_cnt_d = frame_cnt_q;
               if (vs_rise && frame_cnt_q != FRAME_TGT) frame_cnt_d = frame_cnt_q + 4'd1;
               if (frame_cnt_d == FRAME_TGT) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Reset/link flags follow the next state; pixel words follow the current state,
   // except that a drop to IDLE idles the words on that same edge.
   always_comb begin
      serdes_rst_d = (state_d == ST_IDLE) || (state_d == ST_SRST);
      link_up_d    = (state_d == ST_ACTIVE);
      tmds_r_d     = TOK_IDLE;
      tmds_g_d     = TOK_IDLE;
      tmds_b_d     = TOK_IDLE;
      if (state_d != ST_IDLE) begin
         if (state_q == ST_TRAIN) begin
            tmds_b_d = ctrl_tok;
         end else if (state_q == ST_ACTIVE) begin
            if (link.vde) begin
               tmds_r_d = link.enc_r;
               tmds_g_d = link.enc_g;
               tmds_b_d = link.enc_b;
            end else begin
               tmds_b_d = ctrl_tok;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge PixelClk) begin
      if (pRst) begin
         lock_meta_q  <= 1'b0;
         lock_sync_q  <= 1'b0;
         vs_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         lock_cnt_q   <= '0;
         rst_cnt_q    <= '0;
         frame_cnt_q  <= '0;
         serdes_rst_q <= 1'b1;
         link_up_q    <= 1'b0;
         tmds_r_q     <= TOK_IDLE;
         tmds_g_q     <= TOK_IDLE;
         tmds_b_q     <= TOK_IDLE;
      end else begin
         lock_meta_q  <= link.mmcm_locked;
         lock_sync_q  <= lock_meta_q;
         vs_prev_q    <= link.vsync;
         state_q      <= state_d;
         lock_cnt_q   <= lock_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         serdes_rst_q <= serdes_rst_d;
         link_up_q    <= link_up_d;
         tmds_r_q     <= tmds_r_d;
         tmds_g_q     <= tmds_g_d;
         tmds_b_q     <= tmds_b_d;
      end
   end

   assign link.serdes_rst = serdes_rst_q;
   assign link.link_up    = link_up_q;
   assign link.state      = state_q;
   assign link.tmds_r     = tmds_r_q;
   assign link.tmds_g     = tmds_g_q;
   assign link.tmds_b     = tmds_b_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bring-up scenarios followed by randomized traffic, all scored against a
// phase-level reference model of the link sequencer.
module tb_tmds_link_sequencer;

   localparam int LS = 16;
   localparam int RC = 8;
   localparam int TF = 2;
   localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tmds_link_sequencer_if bus ();

   tmds_link_sequencer dut (
      .PixelClk (clk),
      .pRst     (rst),
      .link     (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: phase 0..3 = IDLE/SRST/TRAIN/ACTIVE, one generic progress counter.
   logic       m_p0, m_p1, m_prev_vs;
   int         m_phase, m_cnt;
   logic       exp_serdes, exp_link;
   logic [2:0] exp_state;
   logic [9:0] exp_r, exp_g, exp_b;

   function automatic logic [9:0] tok(input logic vs, input logic hs);
      case ({vs, hs})
         2'b00:   return 10'h354;
         2'b01:   return 10'h0AB;
         2'b10:   return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic lk, rise;
      int   old;
      if (rst) begin
         m_p0 = 0; m_p1 = 0; m_prev_vs = 1; m_phase = 0; m_cnt = 0;
      end else begin
         lk   = m_p1;
         m_p1 = m_p0;
         m_p0 = bus.mmcm_locked;
         rise = bus.vsync && !m_prev_vs;
         m_prev_vs = bus.vsync;
         old = m_phase;
         if (!lk) begin
            m_phase = 0; m_cnt = 0;
         end else if (old == 0) begin
            m_cnt++;
            if (m_cnt >= LS) begin m_phase = 1; m_cnt = 0; end
         end else if (old == 1) begin
            m_cnt++;
            if (m_cnt >= RC) begin m_phase = 2; m_cnt = 0; end
         end else if (old == 2 && rise) begin
            m_cnt++;
            if (m_cnt >= TF) begin m_phase = 3; m_cnt = 0; end
         end
      end
      exp_state  = 3'(m_phase);
      exp_serdes = (m_phase < 2);
      exp_link   = (m_phase == 3);
      exp_r = 10'h354; exp_g = 10'h354; exp_b = 10'h354;
      if (!rst && m_phase != 0) begin
         if (old == 3 && bus.vde) begin
            exp_r = bus.enc_r; exp_g = bus.enc_g; exp_b = bus.enc_b;
         end else if (old == 2 || old == 3) begin
            exp_b = tok(bus.vsync, bus.hsync);
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check({tag, ".state"},      32'(bus.state),      32'(exp_state));
      check({tag, ".serdes_rst"}, 32'(bus.serdes_rst), 32'(exp_serdes));
      check({tag, ".link_up"},    32'(bus.link_up),    32'(exp_link));
      check({tag, ".tmds_r"},     32'(bus.tmds_r),     32'(exp_r));
      check({tag, ".tmds_g"},     32'(bus.tmds_g),     32'(exp_g));
      check({tag, ".tmds_b"},     32'(bus.tmds_b),     32'(exp_b));
   endtask

   task automatic wait_state(input string tag, input logic [2:0] target, input int limit,
                             output int n);
      n = 0;
      while (bus.state !== target && n < limit) begin
         tick(tag);
         n++;
      end
      check({tag, ".reached"}, 32'(bus.state), 32'(target));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, first_srst, drop_left;
      bus.mmcm_locked = 1; bus.vde = 0; bus.hsync = 0; bus.vsync = 0;
      bus.enc_r = '0; bus.enc_g = '0; bus.enc_b = '0;

      // Reset state.
      tick("reset");
      tick("reset");
      check("reset_state", 32'(bus.state), 32'd0);
      check("reset_tmds_g", 32'(bus.tmds_g), 32'h354);
      check("reset_serdes", 32'(bus.serdes_rst), 32'd1);

      // Lock held from release: SRST after 2+16 edges, serdes_rst low after 2+16+8.
      rst = 0;
      n = 0; first_srst = 0;
      while (bus.serdes_rst !== 1'b0 && n < 100) begin
         tick("bringup");
         n++;
         if (first_srst == 0 && bus.state === 3'd1) first_srst = n;
      end
      check("bringup_srst_entry", 32'(first_srst), 32'd18);
      check("bringup_serdes_release", 32'(n), 32'd26);
      check("bringup_train", 32'(bus.state), 32'd2);

      // Training: video enabled on input but output stays control until two vsync edges.
      bus.vde = 1; bus.enc_r = 10'h1F0; bus.enc_g = 10'h2C1; bus.enc_b = 10'h0F3;
      bus.vsync = 1; tick("train_e1");
      check("train_e1_state", 32'(bus.state), 32'd2);
      check("train_e1_ctrl_r", 32'(bus.tmds_r), 32'h354);
      bus.vsync = 0; tick("train_lo"); tick("train_lo");
      bus.vsync = 1; tick("train_e2");
      check("train_e2_active", 32'(bus.state), 32'd3);
      check("train_e2_ctrl_r", 32'(bus.tmds_r), 32'h354);
      check("train_e2_ctrl_b", 32'(bus.tmds_b), 32'h154);
      bus.vsync = 0; tick("active_video");
      check("active_video_r", 32'(bus.tmds_r), 32'h1F0);
      check("active_link_up", 32'(bus.link_up), 32'd1);

      // Control tokens in ACTIVE blanking.
      bus.vde = 0;
      for (int c = 1; c < 4; c++) begin
         {bus.vsync, bus.hsync} = 2'(c);
         tick("active_ctrl");
         check($sformatf("active_ctrl_b_%0d", c), 32'(bus.tmds_b), 32'(TOKS[c]));
         check($sformatf("active_ctrl_r_%0d", c), 32'(bus.tmds_r), 32'h354);
      end
      {bus.vsync, bus.hsync} = 2'b00;

      // Lock loss in ACTIVE: IDLE exactly three edges later.
      bus.mmcm_locked = 0;
      tick("lockloss"); tick("lockloss");
      check("lockloss_still_active", 32'(bus.state), 32'd3);
      tick("lockloss");
      check("lockloss_idle", 32'(bus.state), 32'd0);
      check("lockloss_serdes", 32'(bus.serdes_rst), 32'd1);
      check("lockloss_link", 32'(bus.link_up), 32'd0);

      // One-cycle lock glitch reaching the counter at count 10: SRST 11 edges late.
      bus.mmcm_locked = 1;
      repeat (10) tick("glitch_pre");
      bus.mmcm_locked = 0; tick("glitch");
      bus.mmcm_locked = 1;
      wait_state("glitch_srst", 3'd1, 100, n);
      check("glitch_srst_edges", 32'(n + 11), 32'd29);
      wait_state("glitch_train", 3'd2, 100, n);
      check("glitch_srst_len", 32'(n), 32'(RC));

      // vsync high at reset release and through TRAIN entry is not an edge.
      rst = 1; bus.vsync = 1; tick("vs_reset");
      rst = 0;
      wait_state("vs_hold", 3'd2, 100, n);
      check("vs_hold_train_edges", 32'(n), 32'd26);
      repeat (4) tick("vs_high");
      check("vs_high_no_edge", 32'(bus.state), 32'd2);
      bus.vsync = 0; tick("vs_f1"); bus.vsync = 1; tick("vs_f1");
      check("vs_one_edge", 32'(bus.state), 32'd2);
      bus.vsync = 0; tick("vs_f2"); bus.vsync = 1; tick("vs_f2");
      check("vs_two_edges", 32'(bus.state), 32'd3);

      // Reset asserted mid-operation.
      bus.vde = 1; rst = 1; tick("midrst");
      check("midrst_state", 32'(bus.state), 32'd0);
      check("midrst_tmds_r", 32'(bus.tmds_r), 32'h354);
      rst = 0;

      // Randomized traffic with occasional lock drops and resets.
      drop_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (drop_left > 0) drop_left--;
         else if ($urandom_range(0, 299) == 0) drop_left = $urandom_range(1, 4);
         bus.mmcm_locked = (drop_left == 0);
         rst       = ($urandom_range(0, 1499) == 0);
         bus.vde   = 1'($urandom_range(0, 1));
         bus.hsync = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bus.vsync = ~bus.vsync;
         bus.enc_r = 10'($urandom);
         bus.enc_g = 10'($urandom);
         bus.enc_b = 10'($urandom);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tmds_link_sequencer.md
TMDS_LINK_SEQUENCER -- requirements
Module: tmds_link_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE, default 16: consecutive mmcm_locked=1 cycles required before serializer reset sequencing starts (1..255).
REQ-002 SHALL have parameter RST_CYCLES, default 8: cycles serdes_rst is held after lock qualification (1..255).
REQ-003 SHALL have parameter TRAIN_FRAMES, default 2: vsync rising edges of control-only output before video is enabled (1..15).
REQ-004 PixelClk  in  1  pixel clock; the only clock; all logic on its rising edge.
REQ-005 pRst  in  1  reset, synchronous, active-high.
REQ-006 mmcm_locked  in  1  lock of the MMCM producing PixelClk/SerialClk; may be asynchronous, so it SHALL pass a 2-flop synchronizer first.
REQ-007 vde  in  1  video data enable.
REQ-008 hsync  in  1  horizontal sync.
REQ-009 vsync  in  1  vertical sync.
REQ-010 enc_r, enc_g, enc_b  in  10 each  TMDS-encoded pixel words from the encoders.
REQ-011 serdes_rst  out  1  reset to the three-channel serializer top.
REQ-012 tmds_r, tmds_g, tmds_b  out  10 each  words to the serializer top.
REQ-013 link_up  out  1  high only in ACTIVE.
REQ-014 state  out  3  current state encoding: IDLE=0, SRST=1, TRAIN=2, ACTIVE=3.

Function
REQ-015 SHALL define control tokens {C1,C0}: 00->0x354, 01->0x0AB, 10->0x154, 11->0x2AB.
REQ-016 Control output SHALL be: tmds_b = token({vsync,hsync}), tmds_g = tmds_r = 0x354.
REQ-017 All outputs SHALL be registered; tmds_* at cycle N+1 SHALL reflect vde/hsync/vsync/enc_* and the state at cycle N (1-cycle latency).
REQ-018 IDLE: serdes_rst=1, all tmds_* = 0x354; a lock counter increments on each synchronized lock=1 and clears on lock=0; when it reaches LOCK_STABLE, go to SRST.
REQ-019 SRST: serdes_rst=1, tmds_* = 0x354; after exactly RST_CYCLES cycles in SRST, go to TRAIN.
REQ-020 TRAIN: serdes_rst=0; control output per REQ-016 regardless of vde; count vsync rising edges (vsync=1 and previous sample=0); on the edge making count = TRAIN_FRAMES, go to ACTIVE next cycle.
REQ-021 The output produced in the cycle the final edge is detected SHALL still be control output (TRAIN rules).
REQ-022 ACTIVE: serdes_rst=0, link_up=1; vde=1 -> tmds_* = enc_*; vde=0 -> control output per REQ-016.
REQ-023 Synchronized lock=0 in SRST, TRAIN or ACTIVE SHALL force IDLE on the next edge, with serdes_rst=1, link_up=0, tmds_*=0x354 on that edge; all counters cleared.
REQ-024 The vsync previous-sample register SHALL reset to 1, so vsync already high at reset release or at TRAIN entry is not counted as an edge.
REQ-025 Frame counter SHALL saturate at TRAIN_FRAMES, never wrap; lock counter SHALL saturate at LOCK_STABLE.
REQ-026 Undefined state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-027 pRst=1 at a clock edge SHALL, on that edge: state=IDLE, serdes_rst=1, link_up=0, tmds_r/g/b=0x354, clear all counters and synchronizer flops, set vsync previous-sample to 1; takes priority over all other inputs.
REQ-028 pRst asserted mid-operation (any state) SHALL behave identically to REQ-027; sequencing restarts from IDLE after release.

Verification
REQ-029 Lock held 1 from reset release (defaults) -> serdes_rst deasserts exactly 2(sync)+16+8 cycles later, matching RTL cycle count; state goes 0->1->2.
REQ-030 Lock glitch 0 for one cycle at lock count 10 in IDLE -> counter restarts; SRST entry delayed by that cycle plus 10 more.
REQ-031 In TRAIN, vde=1 with enc_r=0x1F0, vsync pulses twice -> tmds_* stay control tokens; ACTIVE entered the cycle after second rising edge; then vde=1 gives tmds_r=0x1F0 one cycle later.
REQ-032 ACTIVE, vde=0, {vsync,hsync}=01,10,11 -> tmds_b=0x0AB, 0x154, 0x2AB; tmds_g=tmds_r=0x354.
REQ-033 ACTIVE, mmcm_locked drops -> IDLE (state=0), serdes_rst=1, link_up=0, tmds_*=0x354 exactly 3 edges later (2 sync + 1).
REQ-034 vsync=1 at reset release and held through TRAIN entry -> not counted; only subsequent 0->1 edges count.
